jk_bank_arbiter: RTL
====================

Name: jk_bank_arbiter

Overview:
- Shares one WIDTH-bit bank of JK flip-flop bits between two requesters.
- Each requester presents per-bit J/K vectors. The block arbitrates round-robin, latches the winner's J/K, and applies one JK clock step to the bank.
- Completes a 4-phase req/gnt handshake with the winner.
- Sits between control FSMs and the JK state register in the lab datapath. Replaces ad-hoc direct drive of J/K by multiple sources.

Parameters:
WIDTH, 8, number of JK bits in the bank (1..32)

Ports:
Cp  input  1  clock; all state updates on rising edge
CLR  input  1  reset; synchronous, active-high
req0  input  1  requester 0 request; held high until gnt0 seen, then dropped
j0  input  WIDTH  requester 0 J vector
k0  input  WIDTH  requester 0 K vector
req1  input  1  requester 1 request
j1  input  WIDTH  requester 1 J vector
k1  input  WIDTH  requester 1 K vector
gnt0  output  1  grant to requester 0 (registered)
gnt1  output  1  grant to requester 1 (registered)
Q  output  WIDTH  JK bank state
Qbar  output  WIDTH  always ~Q
busy  output  1  high when state != IDLE
last  output  1  index of most recent grant winner

Behaviour:
- Reset: CLR=1 at a rising edge sets the following, in any state:
  - state=IDLE
  - Q=0, Qbar=all ones
  - gnt0=gnt1=0, busy=0
  - last=1, so requester 0 wins the first tie.
- CLR has priority over every other event.
- FSM states: IDLE, APPLY, WAIT.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: that requester wins.
  - Both req: the requester != last wins.
  - On that edge: latch the winner's j/k into internal jl/kl, record the winner, go to APPLY.
  - Q unchanged; gnt stays 0.
- APPLY: on the next edge, per bit i, apply the JK rule:
  - jl=0, kl=0: hold
  - jl=0, kl=1: Q[i]=0
  - jl=1, kl=0: Q[i]=1
  - jl=1, kl=1: Q[i]=~Q[i]
  - Same edge: gnt_winner=1, last=winner, go to WAIT.
  - The commit always happens, even if the winner's req dropped during APPLY.
- WAIT:
  - gnt_winner stays 1 while req_winner=1.
  - First edge sampling req_winner=0: gnt_winner=0, go to IDLE.
  - The loser's req is ignored here.
- Latency: req sampled at edge k; Q and gnt valid after edge k+1.
  - Minimum gnt width is 1 cycle.
  - Minimum request-to-request cycle is 3 edges.
- J/K inputs are sampled only at the IDLE decision edge. Later changes have no effect on the current operation.
- Exactly one of gnt0/gnt1 may be high at a time; both are low outside WAIT.
- busy=1 in APPLY and WAIT.
- Reset mid-operation:
  - Any pending latched J/K is discarded; Q=0.
  - A req still held high is re-arbitrated from IDLE on the first edge with CLR=0.
- Fairness: with both reqs held continuously (each dropping and re-raising after its grant), grants strictly alternate.

Test Plan:
- Reset: CLR=1 for 2 edges with req0=req1=1 -> Q=8'h00, Qbar=8'hFF, gnt0=gnt1=0, busy=0, last=1. After CLR=0, first grant goes to requester 0.
- Single set: req0=1, j0=8'h0F, k0=8'h00 -> busy=1 after edge 1; Q=8'h0F and gnt0=1 after edge 2. gnt0 held until req0=0, then falls on the next edge; busy=0.
- Toggle/latching: from Q=8'h0F, req1=1, j1=k1=8'hFF. Change j1/k1 to 8'h00 after the decision edge -> Q=8'hF0, proving latch-at-decision.
- Simultaneous reqs after reset: req0 (j0=8'hFF, k0=8'h00) and req1 (j1=8'h00, k1=8'h0F) raised together -> gnt0 first, Q=8'hFF. Then gnt1, Q=8'hF0. last reads 0, then 1.
- Fairness: both reqs re-raised immediately after each grant for 6 grants -> grant order 0,1,0,1,0,1; never both gnt high.
- Reset in WAIT: CLR=1 while gnt0=1 and Q=8'h3C -> next edge Q=8'h00, gnt0=0, busy=0. With req0 still high, the operation re-runs after CLR drops.

Source files
------------

// File: rtl/jk_bank_arbiter_if.sv
// Request/grant and JK bank signals shared between two requesters and
// the JK bank arbiter.
interface jk_bank_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] j0;
  logic [WIDTH-1:0] k0;
  logic             req1;
  logic [WIDTH-1:0] j1;
  logic [WIDTH-1:0] k1;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             busy;
  logic             last;

  modport master (
    output req0, j0, k0, req1, j1, k1,
    input  gnt0, gnt1, Q, Qbar, busy, last
  );

  modport slave (
    input  req0, j0, k0, req1, j1, k1,
    output gnt0, gnt1, Q, Qbar, busy, last
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting two requesters one JK clock step each on a
// shared WIDTH-bit JK bank, with a 4-phase req/gnt handshake.
module jk_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic          Cp,
  input  logic          CLR,
  jk_bank_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_jl;
  logic [WIDTH-1:0] r_kl;
  logic             r_win;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;

  logic             w_any_req;
  logic             w_win_next;
  logic             w_req_win;

  function automatic logic [WIDTH-1:0] jk_step(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] j,
    input logic [WIDTH-1:0] k
  );
    logic [WIDTH-1:0] res;
    res = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b01:   res[i] = 1'b0;
        2'b10:   res[i] = 1'b1;
        2'b11:   res[i] = ~q[i];
        default: res[i] = q[i];
      endcase
    end
    return res;
  endfunction

  // On a tie the requester that did not win last time gets the bank.
  always_comb begin
    w_any_req  = bus.req0 | bus.req1;
    w_win_next = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    w_req_win  = r_win ? bus.req1 : bus.req0;
  end

  always_ff @(posedge Cp) begin
    if (CLR) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_last  <= 1'b1;
      r_win   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_win   <= w_win_next;
            r_jl    <= w_win_next ? bus.j1 : bus.j0;
            r_kl    <= w_win_next ? bus.k1 : bus.k0;
            r_state <= APPLY;
          end
        end
        // Commit is unconditional: the request was already accepted.
        APPLY: begin
          r_q     <= jk_step(r_q, r_jl, r_kl);
          r_gnt0  <= ~r_win;
          r_gnt1  <= r_win;
          r_last  <= r_win;
          r_state <= WAIT;
        end
        WAIT: begin
          if (!w_req_win) begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0 = r_gnt0;
  assign bus.gnt1 = r_gnt1;
  assign bus.Q    = r_q;
  assign bus.Qbar = ~r_q;
  assign bus.busy = (r_state != IDLE);
  assign bus.last = r_last;

endmodule
